// File: rtl/genius_pixel_gen_if.sv
// genius_pixel_gen_if: window strobe, pad requests, pixel colour and frame tick between the VGA controller side and the pixel generator
interface genius_pixel_gen_if;
  logic        DISP_EN;
  logic [3:0]  LIGHT;
  logic [23:0] RGB;
  logic        FRAME_TICK;
  modport master (output DISP_EN, LIGHT, input RGB, FRAME_TICK);
  modport slave (input DISP_EN, LIGHT, output RGB, FRAME_TICK);
endinterface

// File: rtl/genius_pixel_gen.sv
// genius_pixel_gen: renders the four Genius pads in the game window, latching pad states once per frame; GENIUS_BORDER_EN adds a black separating cross
module genius_pixel_gen #(
  parameter int G_HS = 360,
  parameter int G_VS = 360,
  parameter int FRAME_GAP = 1024
`ifdef GENIUS_BORDER_EN
  , parameter int BORDER = 8
`endif
) (
  input logic VGA_CLK,
  input logic RESET,
  genius_pixel_gen_if.slave pix
);
  localparam int GW = $clog2(FRAME_GAP + 1);
  logic [8:0] x_q, x_d, y_q, y_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0] light_q, light_d;
  logic tick_q, tick_d;
  logic last_x, last_y;
  logic [1:0] idx;
  logic [7:0] lvl;
  logic [23:0] pad_rgb;
  logic border;
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      x_q <= '0;
      y_q <= '0;
      gap_q <= '0;
      light_q <= '0;
      tick_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      gap_q <= gap_d;
      light_q <= light_d;
      tick_q <= tick_d;
    end
  end
  assign last_x = x_q == 9'(G_HS - 1);
  assign last_y = y_q == 9'(G_VS - 1);
  // Only a gap longer than any line gap resyncs position and samples the pads
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    gap_d = gap_q;
    light_d = light_q;
    tick_d = 1'b0;
    if (pix.DISP_EN) begin
      x_d = last_x ? '0 : x_q + 9'd1;
      y_d = !last_x ? y_q : last_y ? '0 : y_q + 9'd1;
      gap_d = '0;
    end else if (gap_q != GW'(FRAME_GAP)) begin
      gap_d = gap_q + GW'(1);
      if (gap_q == GW'(FRAME_GAP - 1)) begin
        x_d = '0;
        y_d = '0;
        light_d = pix.LIGHT;
        tick_d = 1'b1;
      end
    end
  end
  assign idx = {y_q >= 9'(G_VS / 2), x_q >= 9'(G_HS / 2)};
  assign lvl = light_q[idx] ? 8'hFF : 8'h40;
  always_comb begin
    pad_rgb = (idx == 2'd0) ? {8'h00, lvl, 8'h00} :
              (idx == 2'd1) ? {lvl, 16'h0000} :
              (idx == 2'd2) ? {lvl, lvl, 8'h00} : {16'h0000, lvl};
  end
`ifdef GENIUS_BORDER_EN
  assign border = (x_q >= 9'(G_HS / 2 - BORDER / 2) && x_q < 9'(G_HS / 2 + BORDER / 2)) ||
                  (y_q >= 9'(G_VS / 2 - BORDER / 2) && y_q < 9'(G_VS / 2 + BORDER / 2));
`else
  assign border = 1'b0;
`endif
  assign pix.RGB = (pix.DISP_EN && !border) ? pad_rgb : 24'h000000;
  assign pix.FRAME_TICK = tick_q;
endmodule

// File: tb/tb_genius_pixel_gen.sv
// tb_genius_pixel_gen: directed frames on a reduced 40x30 window plus a default-size instance for reset timing and first-line colours
module tb_genius_pixel_gen;
  localparam int W = 40;
  localparam int H = 30;
  localparam int FG = 64;
`ifdef GENIUS_BORDER_EN
  localparam bit BRD = 1'b1;
`else
  localparam bit BRD = 1'b0;
`endif
  typedef struct {int x; int y; logic [23:0] e;} probe_t;
  logic VGA_CLK = 1'b0;
  logic RESET;
  genius_pixel_gen_if a ();
  genius_pixel_gen_if b ();
  genius_pixel_gen #(.G_HS(W), .G_VS(H), .FRAME_GAP(FG)) dut (.VGA_CLK(VGA_CLK), .RESET(RESET), .pix(a));
  genius_pixel_gen dut_def (.VGA_CLK(VGA_CLK), .RESET(RESET), .pix(b));
  always #5 VGA_CLK = ~VGA_CLK;
  int checks = 0, failures = 0;
  logic [23:0] rgb_a, rgb_b;
  logic tk_a, tk_b;
  int tx, ty, gcnt, ticks, rgb_bad;
  int ta, tb, ata, atb;
  probe_t pq[$];
  int dx [8] = '{0, 175, 176, 179, 180, 183, 184, 359};
  logic [23:0] de [8] = '{24'h004000, 24'h004000, BRD ? 24'h0 : 24'h004000, BRD ? 24'h0 : 24'h004000,
                          BRD ? 24'h0 : 24'h400000, BRD ? 24'h0 : 24'h400000, 24'h400000, 24'h400000};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic ea, input logic eb);
    a.DISP_EN = ea;
    b.DISP_EN = eb;
    #2;
    rgb_a = a.RGB;
    rgb_b = b.RGB;
    @(posedge VGA_CLK);
    #1;
    tk_a = a.FRAME_TICK;
    tk_b = b.FRAME_TICK;
  endtask
  task automatic add(input int x, input int y, input logic [23:0] e);
    probe_t p;
    p.x = x;
    p.y = y;
    p.e = e;
    pq.push_back(p);
  endtask
  task automatic pix();
    step(1'b1, 1'b0);
    for (int i = 0; i < pq.size(); i++)
      if (pq[i].x == tx && pq[i].y == ty) chk($sformatf("px_%0d_%0d", tx, ty), rgb_a, pq[i].e);
    if (tk_a) ticks++;
    gcnt = 0;
    if (tx == W - 1) begin
      tx = 0;
      ty = (ty == H - 1) ? 0 : ty + 1;
    end else tx++;
  endtask
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0);
      if (rgb_a != 0) rgb_bad++;
      if (tk_a) ticks++;
      if (gcnt < FG) begin
        gcnt++;
        if (gcnt == FG) begin
          tx = 0;
          ty = 0;
        end
      end
    end
  endtask
  task automatic frame(input int lines);
    for (int l = 0; l < lines; l++) begin
      for (int i = 0; i < W; i++) pix();
      gap(8);
    end
  endtask
  initial begin
    a.DISP_EN = 1'b0;
    a.LIGHT = 4'b0000;
    b.DISP_EN = 1'b0;
    b.LIGHT = 4'b0000;
    RESET = 1'b1;
    rgb_bad = 0;
    repeat (3) begin
      step(1'b0, 1'b0);
      chk("rst_rgb", rgb_a, 0);
      chk("rst_tick", tk_a, 0);
    end
    RESET = 1'b0;
    ta = 0; tb = 0; ata = 0; atb = 0;
    for (int i = 1; i <= 2000; i++) begin
      step(1'b0, 1'b0);
      if (rgb_a != 0 || rgb_b != 0) rgb_bad++;
      if (tk_a) begin ta++; ata = i; end
      if (tk_b) begin tb++; atb = i; end
    end
    chk("idle_ticks_small", ta, 1);
    chk("idle_tick_at_small", ata, FG);
    chk("idle_ticks_def", tb, 1);
    chk("idle_tick_at_def", atb, 1024);
    chk("idle_rgb", rgb_bad, 0);
    tx = 0; ty = 0; gcnt = FG;
    for (int x = 0; x < 360; x++) begin
      step(1'b0, 1'b1);
      for (int k = 0; k < 8; k++)
        if (dx[k] == x) chk($sformatf("def_px_%0d_0", x), rgb_b, de[k]);
    end
    step(1'b0, 1'b0);
    // Frame A: all dim; LIGHT change mid-frame must not show
    add(0, 0, 24'h004000); add(39, 0, 24'h400000); add(0, 29, 24'h404000); add(39, 29, 24'h000040);
    add(19, 14, BRD ? 24'h0 : 24'h004000); add(20, 14, BRD ? 24'h0 : 24'h400000);
    add(19, 15, BRD ? 24'h0 : 24'h404000); add(20, 15, BRD ? 24'h0 : 24'h000040);
    ticks = 0;
    frame(10);
    a.LIGHT = 4'b0101;
    frame(20);
    chk("frameA_no_tick", ticks, 0);
    gap(100);
    chk("frameA_gap_tick", ticks, 1);
    pq.delete();
    add(2, 2, 24'h00FF00); add(2, 25, 24'hFFFF00); add(30, 2, 24'h400000); add(30, 25, 24'h000040);
    ticks = 0;
    frame(15);
    a.LIGHT = 4'b1010;
    frame(15);
    chk("frameB_no_tick", ticks, 0);
    gap(55);
    a.LIGHT = 4'b1011;
    gap(1);
    chk("tick_capture_cycle", tk_a, 1);
    a.LIGHT = 4'b0101;
    gap(36);
    chk("frameB_gap_tick", ticks, 1);
    pq.delete();
    add(0, 0, 24'h00FF00); add(39, 0, 24'hFF0000); add(0, 29, 24'h404000); add(39, 29, 24'h0000FF);
    ticks = 0;
    frame(31);
    chk("wrap_no_tick", ticks, 0);
    for (int i = 0; i < 25; i++) pix();
    gap(100);
    chk("glitch_gap_tick", ticks, 1);
    pq.delete();
    add(0, 0, 24'h00FF00);
    frame(20);
    for (int i = 0; i < 30; i++) pix();
    RESET = 1'b1;
    step(1'b0, 1'b0);
    RESET = 1'b0;
    tx = 0; ty = 0; gcnt = 0;
    pq.delete();
    add(0, 0, 24'h004000); add(39, 0, 24'h400000);
    ticks = 0;
    frame(5);
    a.LIGHT = 4'b1111;
    gap(100);
    chk("reset_gap_tick", ticks, 1);
    pq.delete();
    add(0, 0, 24'h00FF00); add(39, 0, 24'hFF0000); add(0, 29, 24'hFFFF00); add(39, 29, 24'h0000FF);
    add(15, 2, 24'h00FF00); add(16, 2, BRD ? 24'h0 : 24'h00FF00);
    add(23, 2, BRD ? 24'h0 : 24'hFF0000); add(24, 2, 24'hFF0000);
    add(2, 10, 24'h00FF00); add(2, 11, BRD ? 24'h0 : 24'h00FF00);
    add(2, 18, BRD ? 24'h0 : 24'hFFFF00); add(2, 19, 24'hFFFF00);
    ticks = 0;
    frame(30);
    chk("frameE_no_tick", ticks, 0);
    gap(100);
    chk("frameE_gap_tick", ticks, 1);
    chk("gap_rgb_zero", rgb_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
